// File: rtl/bench_run_ctrl.sv
// bench_run_ctrl: sequences one benchmark run of the SoC core.
// Holds the core in reset, releases it for the run, gates pc_en, and counts
// RUN cycles and retired instructions until the core writes back END_SIG.
//
// Optional feature: define RUN_TIMEOUT_EN to add a RUN-cycle watchdog (TOUT state).
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-low reset
//   start        in   one-cycle request to begin a run (ignored while busy)
//   wb_valid     in   core retired an instruction this cycle
//   wb_result    in   core write-back value (compared only when wb_valid)
//   core_rst     out  active-high reset to the core (low only in RUN)
//   pc_en        out  PC advance enable (high only in RUN)
//   busy         out  high in HOLD and RUN
//   done         out  run finished on END_SIG
//   timeout      out  run aborted by the watchdog (0 without RUN_TIMEOUT_EN)
//   led          out  mirrors done
//   cycle_count  out  RUN cycles of the last or current run (saturating)
//   instr_count  out  wb_valid cycles of the last or current run (saturating)
module bench_run_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter logic [31:0] END_SIG     = 32'hCAFEF00D,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wb_valid,
  input  logic [31:0]      wb_result,
  output logic             core_rst,
  output logic             pc_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             led,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // Hold counter counts down from HOLD_CYCLES-1 to 0, one value per HOLD cycle.
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

`ifdef RUN_TIMEOUT_EN
  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DONE, S_TOUT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} state_t;

  // Watchdog limit has no consumer in this build.
  logic unused_timeout_c;
  assign unused_timeout_c = ^TIMEOUT;
`endif

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cyc_d, ins_d;
  logic [CNT_W-1:0]    cyc_inc, ins_inc;
  logic                end_hit;

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cycle_count;
    ins_d   = instr_count;
    end_hit = wb_valid && (wb_result == END_SIG);
    cyc_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + CNT_W'(1);
    ins_inc = (instr_count == CNT_MAX) ? instr_count : instr_count + CNT_W'(1);

    case (state_q)
`ifdef RUN_TIMEOUT_EN
      S_IDLE, S_DONE, S_TOUT: begin
`else
      S_IDLE, S_DONE: begin
`endif
        if (start) begin
          state_d = S_HOLD;
          hold_d  = HOLD_LOAD;
          cyc_d   = '0;
          ins_d   = '0;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        cyc_d = cyc_inc;
        if (wb_valid) begin
          ins_d = ins_inc;
        end
        // END_SIG takes priority over a watchdog hit in the same cycle.
        if (end_hit) begin
          state_d = S_DONE;
        end
`ifdef RUN_TIMEOUT_EN
        else if (cyc_inc == CNT_W'(TIMEOUT)) begin
          state_d = S_TOUT;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      core_rst    <= 1'b1;
      pc_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      led         <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_count <= cyc_d;
      instr_count <= ins_d;
      core_rst    <= (state_d != S_RUN);
      pc_en       <= (state_d == S_RUN);
      busy        <= (state_d == S_HOLD) || (state_d == S_RUN);
      done        <= (state_d == S_DONE);
      led         <= (state_d == S_DONE);
`ifdef RUN_TIMEOUT_EN
      timeout     <= (state_d == S_TOUT);
`else
      timeout     <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_bench_run_ctrl.sv
// Testbench for bench_run_ctrl: a vector table for reset / first run / restart,
// then hand-written sequences for mid-run reset, the watchdog limit and saturation.
module tb_bench_run_ctrl;

  localparam int unsigned CW   = 5;
  localparam int unsigned HOLD = 4;
  localparam int unsigned TMO  = 20;
  localparam logic [31:0] ESIG = 32'hCAFEF00D;
  localparam int unsigned NV   = 24;

  typedef struct packed {
    logic          core_rst;
    logic          pc_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          led;
    logic [CW-1:0] cyc;
    logic [CW-1:0] ins;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        start;
    logic        wv;
    logic [31:0] wr;
    exp_t        exp;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          wb_valid;
  logic [31:0]   wb_result;
  logic          core_rst;
  logic          pc_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          led;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  exp_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl [NV];

  bench_run_ctrl #(
    .CNT_W      (CW),
    .END_SIG    (ESIG),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wb_valid   (wb_valid),
    .wb_result  (wb_result),
    .core_rst   (core_rst),
    .pc_en      (pc_en),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .led        (led),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk_exp(input logic cr, input logic pe, input logic bz,
                                  input logic dn, input logic to, input int c, input int i);
    exp_t e;
    e.core_rst = cr;
    e.pc_en    = pe;
    e.busy     = bz;
    e.done     = dn;
    e.timeout  = to;
    e.led      = dn;
    e.cyc      = CW'(c);
    e.ins      = CW'(i);
    return e;
  endfunction

  function automatic exp_t e_idle();
    return mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
  endfunction
  function automatic exp_t e_hold();
    return mk_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
  endfunction
  function automatic exp_t e_run(input int c, input int i);
    return mk_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, c, i);
  endfunction
  function automatic exp_t e_done(input int c, input int i);
    return mk_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, c, i);
  endfunction
  function automatic exp_t e_tout(input int c, input int i);
    return mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, c, i);
  endfunction

  function automatic vec_t mk_vec(input logic r, input logic s, input logic v,
                                  input logic [31:0] w, input exp_t e);
    vec_t t;
    t.rst   = r;
    t.start = s;
    t.wv    = v;
    t.wr    = w;
    t.exp   = e;
    return t;
  endfunction

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic compare();
    exp_t  g;
    exp_t  e;
    string nm;
    g.core_rst = core_rst;
    g.pc_en    = pc_en;
    g.busy     = busy;
    g.done     = done;
    g.timeout  = timeout;
    g.led      = led;
    g.cyc      = cycle_count;
    g.ins      = instr_count;
    e  = sb_q.pop_front();
    nm = nm_q.pop_front();
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got core_rst=%b pc_en=%b busy=%b done=%b timeout=%b led=%b cyc=%0d ins=%0d, expected core_rst=%b pc_en=%b busy=%b done=%b timeout=%b led=%b cyc=%0d ins=%0d",
               nm, g.core_rst, g.pc_en, g.busy, g.done, g.timeout, g.led, g.cyc, g.ins,
               e.core_rst, e.pc_en, e.busy, e.done, e.timeout, e.led, e.cyc, e.ins);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, check after the edge.
  task automatic step(input logic r, input logic s, input logic v, input logic [31:0] w,
                      input exp_t e, input string nm);
    rst       = r;
    start     = s;
    wb_valid  = v;
    wb_result = w;
    sb_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    compare();
  endtask

  // Start from IDLE/DONE/TOUT: HOLD_CYCLES hold cycles then the first RUN cycle.
  task automatic launch(input string tag);
    step(1'b1, 1'b1, 1'b0, 32'h0, e_hold(), {tag, "_start"});
    for (int h = 1; h < int'(HOLD); h++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, e_hold(), $sformatf("%s_hold%0d", tag, h));
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, e_run(0, 0), {tag, "_run0"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    wb_valid  = 1'b0;
    wb_result = 32'h0;

    // Reset, first run of 10 RUN cycles (8 retirements), start mid-run, restart from DONE.
    tbl[0]  = mk_vec(1'b0, 1'b0, 1'b0, 32'h0,        e_idle());
    tbl[1]  = mk_vec(1'b0, 1'b1, 1'b1, ESIG,         e_idle());
    tbl[2]  = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_idle());
    tbl[3]  = mk_vec(1'b1, 1'b1, 1'b0, 32'h0,        e_hold());
    tbl[4]  = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_hold());
    tbl[5]  = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_hold());
    tbl[6]  = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_hold());
    tbl[7]  = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_run(0, 0));
    tbl[8]  = mk_vec(1'b1, 1'b0, 1'b1, 32'h1,        e_run(1, 1));
    tbl[9]  = mk_vec(1'b1, 1'b0, 1'b0, ESIG,         e_run(2, 1));
    tbl[10] = mk_vec(1'b1, 1'b0, 1'b1, 32'h2,        e_run(3, 2));
    tbl[11] = mk_vec(1'b1, 1'b1, 1'b1, 32'h3,        e_run(4, 3));
    tbl[12] = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_run(5, 3));
    tbl[13] = mk_vec(1'b1, 1'b0, 1'b1, 32'hCAFEF00C, e_run(6, 4));
    tbl[14] = mk_vec(1'b1, 1'b0, 1'b1, 32'h5,        e_run(7, 5));
    tbl[15] = mk_vec(1'b1, 1'b0, 1'b1, 32'h6,        e_run(8, 6));
    tbl[16] = mk_vec(1'b1, 1'b0, 1'b1, 32'h7,        e_run(9, 7));
    tbl[17] = mk_vec(1'b1, 1'b0, 1'b1, ESIG,         e_done(10, 8));
    tbl[18] = mk_vec(1'b1, 1'b0, 1'b1, ESIG,         e_done(10, 8));
    tbl[19] = mk_vec(1'b1, 1'b1, 1'b0, 32'h0,        e_hold());
    tbl[20] = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_hold());
    tbl[21] = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_hold());
    tbl[22] = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_hold());
    tbl[23] = mk_vec(1'b1, 1'b0, 1'b0, 32'h0,        e_run(0, 0));

    for (int i = 0; i < int'(NV); i++) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].wv, tbl[i].wr, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Reset on the 5th RUN cycle discards the run, even with END_SIG present.
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0, e_run(k, k), $sformatf("mrst_run%0d", k));
    end
    step(1'b0, 1'b0, 1'b1, ESIG, e_idle(), "mrst_reset");

    // Restart; a start pulse during HOLD must not reload the hold counter.
    step(1'b1, 1'b1, 1'b0, 32'h0, e_hold(), "rerun_start");
    step(1'b1, 1'b1, 1'b0, 32'h0, e_hold(), "rerun_hold_start");
    step(1'b1, 1'b0, 1'b0, 32'h0, e_hold(), "rerun_hold2");
    step(1'b1, 1'b0, 1'b0, 32'h0, e_hold(), "rerun_hold3");
    step(1'b1, 1'b0, 1'b0, 32'h0, e_run(0, 0), "rerun_run0");
    step(1'b1, 1'b0, 1'b1, ESIG, e_done(1, 1), "rerun_end");

    // END_SIG on the cycle that reaches the watchdog limit: DONE wins.
    launch("lim");
    for (int k = 1; k < int'(TMO); k++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0, e_run(k, k), $sformatf("lim_run%0d", k));
    end
    step(1'b1, 1'b0, 1'b1, ESIG, e_done(int'(TMO), int'(TMO)), "lim_end");

    // Long run without END_SIG: watchdog abort, or counter saturation without it.
    launch("long");
`ifdef RUN_TIMEOUT_EN
    for (int k = 1; k <= 26; k++) begin
      if (k < int'(TMO)) begin
        step(1'b1, 1'b0, 1'b1, 32'h0, e_run(k, k), $sformatf("long_run%0d", k));
      end else begin
        step(1'b1, 1'b0, 1'b1, (k == 25) ? ESIG : 32'h0,
             e_tout(int'(TMO), int'(TMO)), $sformatf("long_tout%0d", k));
      end
    end
`else
    for (int k = 1; k <= 35; k++) begin
      step(1'b1, 1'b0, 1'b1, 32'h0, e_run((k > 31) ? 31 : k, (k > 31) ? 31 : k),
           $sformatf("long_run%0d", k));
    end
    step(1'b1, 1'b0, 1'b1, ESIG, e_done(31, 31), "long_end");
`endif
    step(1'b1, 1'b1, 1'b0, 32'h0, e_hold(), "long_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
